reset_logic_sequencer: RTL and testbench

Staged reset-release sequencer that sits upstream of the reset delay chains. It filters a synchronized hardware reset request and accepts a software reset pulse. It holds all downstream domains in reset, then releases them one domain at a time, in index order, at a fixed spacing. Each `stage_resetn[k]` drives the `data_in` of a per-domain reset delay chain.

---
 rtl/reset_logic_sequencer_if.sv | 29 ++
 rtl/reset_logic_sequencer.sv | 133 +++++++++++++
 tb/tb_reset_logic_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/reset_logic_sequencer_if.sv
// Reset request inputs and staged active-low domain resets of the reset-release sequencer.
interface reset_logic_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    logic                  rst_req;
    logic                  sw_rst_pulse;
    logic [NUM_STAGES-1:0] stage_resetn;
    logic                  busy;
    logic                  done;
    logic [1:0]            cause;

    modport master (
        output rst_req,
        output sw_rst_pulse,
        input  stage_resetn,
        input  busy,
        input  done,
        input  cause
    );

    modport slave (
        input  rst_req,
        input  sw_rst_pulse,
        output stage_resetn,
        output busy,
        output done,
        output cause
    );
endinterface

// File: rtl/reset_logic_sequencer.sv
// Filters hw/sw reset requests, holds all domains in reset, then releases them in index order.
// Registered outputs: sw trigger reaches stage_resetn in 1 cycle, hw in FILTER_CYCLES; no backpressure.
module reset_logic_sequencer #(
    parameter int NUM_STAGES    = 4,
    parameter int HOLD_CYCLES   = 16,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    reset_logic_sequencer_if.slave    bus
);
    localparam int CW = $clog2(HOLD_CYCLES);
    localparam int IW = $clog2(NUM_STAGES + 1);
    localparam int FW = $clog2(FILTER_CYCLES + 1);

    typedef enum logic [1:0] {ST_HOLD, ST_RELEASE, ST_IDLE} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [FW-1:0]         filt_q, filt_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [1:0]            cause_q, cause_d;
    logic                  hw_trig;
    logic                  cnt_last;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            idx_q   <= '0;
            filt_q  <= '0;
            stage_q <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            filt_q  <= filt_d;
            stage_q <= stage_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        stage_d  = stage_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cause_d  = cause_q;
        cnt_last = (cnt_q == CW'(HOLD_CYCLES - 1));

        // Filter saturates so hw_trig fires once per continuous high level.
        hw_trig = bus.rst_req && (filt_q == FW'(FILTER_CYCLES - 1));
        if (!bus.rst_req) begin
            filt_d = '0;
        end else if (filt_q == FW'(FILTER_CYCLES)) begin
            filt_d = filt_q;
        end else begin
            filt_d = filt_q + FW'(1);
        end

        if (hw_trig || bus.sw_rst_pulse) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            stage_d = '0;
            busy_d  = 1'b1;
            cause_d = {bus.sw_rst_pulse, hw_trig};
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (bus.rst_req) begin
                        cnt_d = '0;
                    end else if (cnt_last) begin
                        stage_d[0] = 1'b1;
                        cnt_d      = '0;
                        idx_d      = IW'(1);
                        if (NUM_STAGES == 1) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (cnt_last) begin
                        for (int k = 0; k < NUM_STAGES; k++) begin
                            if (idx_q == IW'(k)) stage_d[k] = 1'b1;
                        end
                        idx_d = idx_q + IW'(1);
                        cnt_d = '0;
                        if (idx_q == IW'(NUM_STAGES - 1)) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_IDLE: begin
                    stage_d = '1;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                    idx_d   = '0;
                    stage_d = '0;
                    busy_d  = 1'b1;
                end
            endcase
        end
    end

    assign bus.stage_resetn = stage_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.cause        = cause_q;
endmodule

// File: tb/tb_reset_logic_sequencer.sv
// Directed bench for the staged reset-release sequencer with default parameters.
module tb_reset_logic_sequencer;
    logic clock;
    logic reset;
    int   n_checks;
    int   n_fail;

    reset_logic_sequencer_if #(.NUM_STAGES(4)) bus ();

    reset_logic_sequencer #(
        .NUM_STAGES(4),
        .HOLD_CYCLES(16),
        .FILTER_CYCLES(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] stg, input logic [31:0] bsy,
                           input logic [31:0] dn, input logic [31:0] cs);
        check({tag, ".stage"}, 32'(bus.stage_resetn), stg);
        check({tag, ".busy"},  32'(bus.busy), bsy);
        check({tag, ".done"},  32'(bus.done), dn);
        check({tag, ".cause"}, 32'(bus.cause), cs);
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        reset            = 1'b1;
        bus.rst_req      = 1'b0;
        bus.sw_rst_pulse = 1'b0;

        // Power-on sequence
        step(2);
        chk_out("rst", 'h0, 1, 0, 0);
        reset = 1'b0;
        step(15);
        chk_out("por_e15", 'h0, 1, 0, 0);
        step(1);
        chk_out("por_e16", 'h1, 1, 0, 0);
        step(16);
        check("por_e32", 32'(bus.stage_resetn), 'h3);
        step(16);
        check("por_e48", 32'(bus.stage_resetn), 'h7);
        step(15);
        chk_out("por_e63", 'h7, 1, 0, 0);
        step(1);
        chk_out("por_e64", 'hf, 0, 1, 0);
        step(1);
        chk_out("por_e65", 'hf, 0, 0, 0);

        // Short glitches are filtered out
        for (int len = 1; len <= 3; len++) begin
            bus.rst_req = 1'b1;
            step(len);
            bus.rst_req = 1'b0;
            step(3);
            chk_out($sformatf("glitch%0d", len), 'hf, 0, 0, 0);
        end

        // Long hw request: accepted on 4th sample, hold lasts while request stays high
        bus.rst_req = 1'b1;
        step(3);
        check("hw_s3", 32'(bus.stage_resetn), 'hf);
        step(1);
        chk_out("hw_s4", 'h0, 1, 0, 1);
        step(36);
        check("hw_s40", 32'(bus.stage_resetn), 'h0);
        bus.rst_req = 1'b0;
        step(15);
        check("hw_fall15", 32'(bus.stage_resetn), 'h0);
        step(1);
        chk_out("hw_fall16", 'h1, 1, 0, 1);
        step(48);
        chk_out("hw_end", 'hf, 0, 1, 1);
        step(1);

        // sw pulse mid-RELEASE restarts the sequence
        bus.sw_rst_pulse = 1'b1;
        step(1);
        bus.sw_rst_pulse = 1'b0;
        chk_out("sw_t0", 'h0, 1, 0, 2);
        step(39);
        check("sw_e39", 32'(bus.stage_resetn), 'h3);
        bus.sw_rst_pulse = 1'b1;
        step(1);
        bus.sw_rst_pulse = 1'b0;
        chk_out("sw_restart", 'h0, 1, 0, 2);
        step(15);
        check("sw_r15", 32'(bus.stage_resetn), 'h0);
        step(1);
        check("sw_r16", 32'(bus.stage_resetn), 'h1);
        step(16);
        check("sw_r32", 32'(bus.stage_resetn), 'h3);
        step(16);
        check("sw_r48", 32'(bus.stage_resetn), 'h7);
        step(16);
        chk_out("sw_r64", 'hf, 0, 1, 2);
        step(1);

        // sw pulse coincident with hw_trig
        bus.rst_req = 1'b1;
        step(3);
        bus.sw_rst_pulse = 1'b1;
        step(1);
        bus.sw_rst_pulse = 1'b0;
        bus.rst_req      = 1'b0;
        chk_out("both", 'h0, 1, 0, 3);
        step(63);
        chk_out("both_e63", 'h7, 1, 0, 3);
        step(1);
        chk_out("both_e64", 'hf, 0, 1, 3);
        step(1);

        // sw pulse on the last-release edge: restart wins, no done
        bus.sw_rst_pulse = 1'b1;
        step(1);
        bus.sw_rst_pulse = 1'b0;
        step(63);
        check("last_e63", 32'(bus.stage_resetn), 'h7);
        bus.sw_rst_pulse = 1'b1;
        step(1);
        bus.sw_rst_pulse = 1'b0;
        chk_out("last_coinc", 'h0, 1, 0, 2);

        // Block reset mid-sequence
        step(49);
        check("mid_e49", 32'(bus.stage_resetn), 'h7);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk_out("mid_rst", 'h0, 1, 0, 0);
        step(16);
        chk_out("mid_e16", 'h1, 1, 0, 0);
        step(48);
        chk_out("mid_e64", 'hf, 0, 1, 0);
        step(1);
        chk_out("mid_e65", 'hf, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
